// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits,
// odd parity and stop, then checks the device ACK. Lines are open-collector.
module ps2_host_tx #(
   parameter int INHIBIT_CYC = 2400,
   parameter int TIMEOUT_CYC = 48000,
   parameter int FILT        = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_req,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error,
   output logic       rx_inhibit,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);

   localparam int CMAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int FW   = $clog2(FILT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_REQ, S_DATA, S_ACK, S_WAIT, S_ERR
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      clk_s_q, dat_s_q;
   logic            clk_f_q, clk_f_d;
   logic [FW-1:0]   fcnt_q, fcnt_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [3:0]      bit_q, bit_d;
   logic [9:0]      sh_q, sh_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            clk_oe_q, clk_oe_d;
   logic            dat_oe_q, dat_oe_d;
   logic            fall;
   logic            tmo;
   logic            dat_s;

   assign dat_s = dat_s_q[1];

   // Clock level only moves after FILT consecutive samples disagree with it.
   always_comb begin
      clk_f_d = clk_f_q;
      fcnt_d  = '0;
      fall    = 1'b0;
      if (clk_s_q[1] != clk_f_q) begin
         if (fcnt_q == FW'(FILT - 1)) begin
            clk_f_d = clk_s_q[1];
            fall    = clk_f_q;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
   end

   assign tmo = (cnt_q == CW'(TIMEOUT_CYC - 1));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      sh_d     = sh_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      clk_oe_d = clk_oe_q;
      dat_oe_d = dat_oe_q;
      unique case (state_q)
         S_IDLE: begin
            if (tx_req && !busy_q) begin
               sh_d     = {1'b1, ~^tx_data, tx_data};
               bit_d    = '0;
               cnt_d    = '0;
               busy_d   = 1'b1;
               clk_oe_d = 1'b1;
               state_d  = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(INHIBIT_CYC - 2)) dat_oe_d = 1'b1;
            if (cnt_q == CW'(INHIBIT_CYC - 1)) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b1;
               cnt_d    = '0;
               state_d  = S_REQ;
            end
         end
         S_REQ, S_DATA: begin
            cnt_d = cnt_q + 1'b1;
            if (fall) begin
               cnt_d    = '0;
               dat_oe_d = ~sh_q[0];
               sh_d     = {1'b0, sh_q[9:1]};
               bit_d    = bit_q + 1'b1;
               state_d  = (bit_q == 4'd9) ? S_ACK : S_DATA;
            end else if (tmo) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b0;
               state_d  = S_ERR;
            end
         end
         S_ACK: begin
            cnt_d = cnt_q + 1'b1;
            if (fall) begin
               cnt_d   = '0;
               state_d = dat_s ? S_ERR : S_WAIT;
            end else if (tmo) begin
               state_d = S_ERR;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (clk_f_q && dat_s) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else if (tmo) begin
               state_d = S_ERR;
            end
         end
         S_ERR: begin
            err_d    = 1'b1;
            busy_d   = 1'b0;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            cnt_d    = '0;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_s_q  <= 2'b11;
         dat_s_q  <= 2'b11;
         clk_f_q  <= 1'b1;
         fcnt_q   <= '0;
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         sh_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         clk_oe_q <= 1'b0;
         dat_oe_q <= 1'b0;
      end else begin
         clk_s_q  <= {clk_s_q[0], ps2_clk_i};
         dat_s_q  <= {dat_s_q[0], ps2_dat_i};
         clk_f_q  <= clk_f_d;
         fcnt_q   <= fcnt_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         sh_q     <= sh_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         clk_oe_q <= clk_oe_d;
         dat_oe_q <= dat_oe_d;
      end
   end

   assign tx_busy    = busy_q;
   assign rx_inhibit = busy_q;
   assign tx_done    = done_q;
   assign tx_error   = err_q;
   assign ps2_clk_oe = clk_oe_q;
   assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the
// host and the observed line bits are compared with the expected frame.
module tb_ps2_host_tx;

   localparam int INH  = 20;
   localparam int TO   = 400;
   localparam int FILT = 4;
   localparam int HALF = 20;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_req = 1'b0;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;
   logic       tx_busy, tx_done, tx_error, rx_inhibit;
   logic       ps2_clk_oe, ps2_dat_oe;
   logic       ps2_clk_i, ps2_dat_i;

   int errors = 0;
   int checks = 0;
   int n_done = 0;
   int n_err  = 0;
   int n_both = 0;
   int cyc    = 0;
   int bstart = 0;
   int blen   = 0;
   logic bprev = 1'b0;

   assign ps2_clk_i = dev_clk & ~ps2_clk_oe;
   assign ps2_dat_i = dev_dat & ~ps2_dat_oe;

   ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO), .FILT(FILT)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .tx_data    (tx_data),
      .tx_req     (tx_req),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .tx_error   (tx_error),
      .rx_inhibit (rx_inhibit),
      .ps2_clk_i  (ps2_clk_i),
      .ps2_dat_i  (ps2_dat_i),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #2;
      cyc++;
      if (tx_done) n_done++;
      if (tx_error) n_err++;
      if (tx_done && tx_error) n_both++;
      if (tx_busy && !bprev) bstart = cyc;
      if (!tx_busy && bprev) blen = cyc - bstart;
      bprev = tx_busy;
   end

   // Expected line sequence after the start bit: data LSB first, odd parity, stop.
   function automatic logic [9:0] exp_frame(input logic [7:0] d);
      int ones;
      ones = $countones(d);
      return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
   endfunction

   task automatic start_req(input logic [7:0] d);
      @(negedge clk);
      tx_data = d;
      tx_req  = 1'b1;
      @(negedge clk);
      tx_req  = 1'b0;
   endtask

   task automatic device_frame(input bit ack, input int nf,
                               output logic [9:0] seen);
      int w;
      w = 0;
      seen = '0;
      while (ps2_clk_oe !== 1'b0 && w < INH * 4) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b1) begin
         errors++;
         $display("FAIL start_bit: clk_oe=%b dat_oe=%b want 0/1",
                  ps2_clk_oe, ps2_dat_oe);
         return;
      end
      repeat (5) @(negedge clk);
      for (int k = 1; k <= nf; k++) begin
         if (k == 11 && ack) begin
            dev_dat = 1'b0;
            repeat (2) @(negedge clk);
         end
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         if (k <= 10) seen[k-1] = ~ps2_dat_oe;
         dev_clk = 1'b1;
         dev_dat = 1'b1;
         if (k < 11) repeat (HALF) @(negedge clk);
      end
   endtask

   task automatic wait_outcome(input int d0, input int e0, output int res);
      res = 0;
      for (int i = 0; i < TO * 2 && n_done == d0 && n_err == e0; i++)
         @(negedge clk);
      if (n_done != d0) res = 1;
      else if (n_err != e0) res = 2;
   endtask

   task automatic do_frame(input logic [7:0] d, input string name);
      int d0, e0, res;
      logic [9:0] seen;
      d0 = n_done;
      e0 = n_err;
      start_req(d);
      device_frame(1'b1, 11, seen);
      wait_outcome(d0, e0, res);
      checks++;
      if (seen !== exp_frame(d)) begin
         errors++;
         $display("FAIL %s bits: got %b want %b", name, seen, exp_frame(d));
      end
      checks++;
      if (res != 1 || n_err != e0) begin
         errors++;
         $display("FAIL %s outcome: got res=%0d errs=%0d want done only",
                  name, res, n_err - e0);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({tx_busy, tx_done, tx_error, rx_inhibit, ps2_clk_oe, ps2_dat_oe}
          !== 6'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b want 000000",
                  {tx_busy, tx_done, tx_error, rx_inhibit, ps2_clk_oe, ps2_dat_oe});
      end
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (tx_busy !== 1'b0 || ps2_clk_oe !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: busy=%b clk_oe=%b want 0/0",
                  tx_busy, ps2_clk_oe);
      end
   endtask

   task automatic test_cmd_ed();
      int d0;
      d0 = n_done;
      do_frame(8'hED, "cmd_ed");
      repeat (3) @(negedge clk);
      checks++;
      if (n_done != d0 + 1) begin
         errors++;
         $display("FAIL ed_done_pulses: got %0d want 1", n_done - d0);
      end
      checks++;
      if (blen < INH + 20 * HALF || blen > INH + 24 * HALF) begin
         errors++;
         $display("FAIL ed_busy_len: got %0d want %0d..%0d",
                  blen, INH + 20 * HALF, INH + 24 * HALF);
      end
   endtask

   task automatic test_back_to_back();
      int d0, e0, res;
      logic [9:0] seen;
      d0 = n_done;
      e0 = n_err;
      start_req(8'h02);
      device_frame(1'b1, 11, seen);
      wait_outcome(d0, e0, res);
      checks++;
      if (seen !== exp_frame(8'h02) || res != 1) begin
         errors++;
         $display("FAIL b2b_first: got %b res=%0d want %b res=1",
                  seen, res, exp_frame(8'h02));
      end
      tx_data = 8'hED;
      tx_req  = 1'b1;
      @(negedge clk);
      tx_req  = 1'b0;
      checks++;
      if (tx_busy !== 1'b1 || rx_inhibit !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept: busy=%b inhibit=%b want 1/1",
                  tx_busy, rx_inhibit);
      end
      d0 = n_done;
      device_frame(1'b1, 11, seen);
      wait_outcome(d0, e0, res);
      checks++;
      if (seen !== exp_frame(8'hED) || res != 1) begin
         errors++;
         $display("FAIL b2b_second: got %b res=%0d want %b res=1",
                  seen, res, exp_frame(8'hED));
      end
   endtask

   task automatic test_no_clock();
      int c, d0, e0;
      d0 = n_done;
      e0 = n_err;
      start_req(8'h55);
      c = 0;
      while (ps2_clk_oe === 1'b1 && c < INH * 4) begin
         c++;
         @(negedge clk);
      end
      checks++;
      if (c != INH) begin
         errors++;
         $display("FAIL inhibit_len: got %0d want %0d", c, INH);
      end
      c = 0;
      while (n_err == e0 && c < TO * 2) begin
         c++;
         @(negedge clk);
      end
      checks++;
      if (c < TO - 2 || c > TO + 4) begin
         errors++;
         $display("FAIL timeout_len: got %0d want about %0d", c, TO);
      end
      checks++;
      if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || tx_busy !== 1'b0
          || n_done != d0) begin
         errors++;
         $display("FAIL timeout_release: clk_oe=%b dat_oe=%b busy=%b dones=%0d want 0",
                  ps2_clk_oe, ps2_dat_oe, tx_busy, n_done - d0);
      end
   endtask

   task automatic test_nack();
      int d0, e0, res;
      logic [9:0] seen;
      d0 = n_done;
      e0 = n_err;
      start_req(8'hA7);
      device_frame(1'b0, 11, seen);
      wait_outcome(d0, e0, res);
      checks++;
      if (res != 2 || n_done != d0) begin
         errors++;
         $display("FAIL nack_outcome: got res=%0d dones=%0d want error only",
                  res, n_done - d0);
      end
      checks++;
      if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || tx_busy !== 1'b0) begin
         errors++;
         $display("FAIL nack_release: clk_oe=%b dat_oe=%b busy=%b want 0",
                  ps2_clk_oe, ps2_dat_oe, tx_busy);
      end
   endtask

   task automatic test_reset_mid();
      logic [9:0] seen;
      start_req(8'hFF);
      device_frame(1'b1, 5, seen);
      #3 reset_n = 1'b0;
      #1;
      checks++;
      if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || tx_busy !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: clk_oe=%b dat_oe=%b busy=%b want 0",
                  ps2_clk_oe, ps2_dat_oe, tx_busy);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      do_frame(8'h4B, "post_reset");
   endtask

   task automatic test_glitch();
      int d0, e0, res, w;
      logic [9:0] seen;
      d0 = n_done;
      e0 = n_err;
      start_req(8'h3C);
      w = 0;
      while (ps2_clk_oe !== 1'b0 && w < INH * 4) begin
         @(negedge clk);
         w++;
      end
      repeat (3) @(negedge clk);
      dev_clk = 1'b0;
      repeat (FILT - 1) @(negedge clk);
      dev_clk = 1'b1;
      repeat (4) @(negedge clk);
      tx_data = 8'hC3;
      tx_req  = 1'b1;
      @(negedge clk);
      tx_req  = 1'b0;
      repeat (6) @(negedge clk);
      device_frame(1'b1, 11, seen);
      wait_outcome(d0, e0, res);
      checks++;
      if (seen !== exp_frame(8'h3C) || res != 1) begin
         errors++;
         $display("FAIL glitch_frame: got %b res=%0d want %b res=1",
                  seen, res, exp_frame(8'h3C));
      end
      repeat (INH + 10) @(negedge clk);
      checks++;
      if (tx_busy !== 1'b0 || n_done != d0 + 1) begin
         errors++;
         $display("FAIL ignored_req: busy=%b dones=%0d want 0 and 1",
                  tx_busy, n_done - d0);
      end
   endtask

   task automatic test_random();
      logic [7:0] d;
      for (int i = 0; i < 4; i++) begin
         d = 8'($urandom_range(0, 255));
         do_frame(d, "random");
      end
   endtask

   initial begin
      test_reset();
      test_cmd_ed();
      test_back_to_back();
      test_no_clock();
      test_nack();
      test_reset_mid();
      test_glitch();
      test_random();
      checks++;
      if (n_both != 0) begin
         errors++;
         $display("FAIL exclusive_pulses: got %0d overlaps want 0", n_both);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
